dmem_lsu: RTL
=============

# dmem_lsu

Load/store initiator that sits between the core's memory stage and the data memory (async read, sync byte-enabled write). Accepts one byte/half/word request at a time over a valid/ready handshake and drives the memory's word-addressed port. Generates write byte enables and store-data lane rotation, and aligns and sign/zero-extends load data. Splits accesses that cross a word boundary into two memory cycles.

## Interface
- `DWIDTH`, 32: memory word width; only 32 is supported.
- `AWIDTH`, 10: memory word-address width; byte address is `AWIDTH+2` bits.

- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; transfer occurs when `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `req_unsigned`  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores.
- `req_addr`  in  AWIDTH+2  byte address; any alignment is allowed.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle pulse per completed request; no backpressure.
- `resp_rdata`  out  32  extended load data; 0 for stores.
- `dmem_en`  out  1  memory write enable.
- `dmem_wbe`  out  4  memory byte-write enables.
- `dmem_addr`  out  AWIDTH  memory word address.
- `dmem_din`  out  32  memory write data.
- `dmem_dout`  in  32  memory read data; combinational from `dmem_addr`.

## Operation
- States: IDLE, ACC0, ACC1, RESP.
  - IDLE → ACC0 on handshake; the request is registered.
  - ACC0 → ACC1 if the access is split, else → RESP.
  - ACC1 → RESP.
  - RESP → IDLE.
- Definitions: `o = addr[1:0]`; `n = 1 << size` (1, 2 or 4 bytes); `w0 = addr[AWIDTH+1:2]`.
- Split condition: `o + n > 4`. Possible cases: half at o=3; word at o=1, 2 or 3.
- Byte-lane mask: `m8 = ((1<<n)-1) << o`, an 8-bit value.
  - ACC0: `dmem_addr = w0`, `dmem_wbe = m8[3:0]`.
  - ACC1: `dmem_addr = w0+1` modulo `2^AWIDTH` (last word wraps to 0), `dmem_wbe = m8[7:4]`.
- Stores:
  - `dmem_en = 1` in ACC0 and ACC1.
  - `dmem_din = req_wdata` rotated left by `8*o` bits; the same value is used in both cycles.
- Loads:
  - `dmem_en = 0` and `dmem_wbe = 0`.
  - `dmem_dout` is captured into a low-word register in ACC0 and a high-word register in ACC1.
  - Result = `({hi,lo} >> 8*o)`, low `8n` bits kept, then sign- or zero-extended to 32 bits.
- Outside ACC0/ACC1: `dmem_en = 0`, `dmem_wbe = 0`, `dmem_addr` and `dmem_din` are don't-care (drive 0).
- `resp_valid` and `resp_rdata` are registered and valid in RESP only. `resp_rdata` holds 0 otherwise.

## Timing
- Handshake on edge T.
  - Aligned access: ACC0 in cycle T+1, `resp_valid` in cycle T+2.
  - Split access: ACC1 in cycle T+2, `resp_valid` in cycle T+3.
- `req_ready` returns high the cycle after RESP. Throughput is one request per 3 (aligned) or 4 (split) cycles.
- Store bytes commit on the edge ending each ACC cycle.
- A load issued after a store observes the stored bytes, since the store commits before RESP.
- Reset values: state IDLE, `req_ready = 0` while `rst` is asserted, `resp_valid = 0`, `resp_rdata = 0`, `dmem_en = 0`, `dmem_wbe = 0`.
- Reset mid-operation: the in-flight request is dropped with no response.
  - `dmem_en` is gated combinationally by `!rst`, so no write occurs in the reset cycle.
  - A split store interrupted after ACC0 leaves only the first-word bytes written. This is accepted behaviour.
- Request inputs are sampled only at the handshake; changes afterwards are ignored.

## Structure
- Package `dmem_lsu_pkg`:
  - size encodings `SIZE_B`, `SIZE_H`, `SIZE_W`;
  - state enum `lsu_state_t`;
  - function computing `m8` from (size, offset).
- Sub-module `dmem_lsu_align`: combinational lane logic. It performs store rotation, mask generation, and load shift/extend from `{hi,lo}`, o, size and unsigned.
- Top level `dmem_lsu` holds the FSM and registers.

## Test plan
- Aligned word store then load: store 0xDEADBEEF at addr 0x10; memory word 4 = 0xDEADBEEF with `wbe=4'hF`; load returns 0xDEADBEEF at T+2.
- Byte loads: word 0 = 0x80FF7F01. Signed load at addr 3 → 0xFFFFFF80; unsigned load at addr 3 → 0x00000080; signed load at addr 1 → 0x0000007F.
- Half store at addr 6: data 0x1234 → word 1 written with `wbe=4'b1100`, `din[31:16]=0x1234`; other bytes unchanged.
- Split word store at addr 0x0D, data 0xAABBCCDD:
  - ACC0: word 3 `wbe=4'b1110`; ACC1: word 4 `wbe=4'b0001`.
  - A subsequent load at 0x0D returns 0xAABBCCDD at T+3.
- Wrap: word store at byte address `2^(AWIDTH+2)-2` writes the top word's bytes 3..2 and word 0's bytes 1..0. Load returns the same value.
- Reset after ACC0 of a split store: no `resp_valid`, `dmem_en=0` in the reset cycle, `req_ready=1` in the first cycle after reset deasserts, next request completes normally.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - shared encodings, FSM states and lane-mask helper for dmem_lsu
package dmem_lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // 8-lane byte mask spanning two consecutive words: low nibble is the
    // first word, high nibble the second (non-zero only for split accesses).
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            SIZE_B:  base = 8'h01;
            SIZE_H:  base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// rtl/dmem_lsu_align.sv - combinational byte-lane logic: store rotation, lane mask, load shift/extend
//
// Ports:
//   wdata  in  32  right-justified store data
//   off    in  2   byte offset within the first word
//   size   in  2   access size (byte/half/word, 3 acts as word)
//   uns    in  1   zero-extend loads when set
//   lo     in  32  first memory word of the access
//   hi     in  24  low three bytes of the second word (top byte is never reachable)
//   din    out 32  store data rotated onto its byte lanes
//   mask   out 8   lane mask across {second word, first word}
//   rdata  out 32  aligned and extended load result
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] lo,
    input  logic [23:0] hi,
    output logic [31:0] din,
    output logic [7:0]  mask,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    assign mask = lane_mask(size, off);

    always_comb begin
        din = wdata;
        case (off)
            2'd0: din = wdata;
            2'd1: din = {wdata[23:0], wdata[31:24]};
            2'd2: din = {wdata[15:0], wdata[31:16]};
            2'd3: din = {wdata[7:0],  wdata[31:8]};
            default: din = wdata;
        endcase
    end

    // {hi,lo} >> 8*off; an access ends at most at byte 6, so hi[31:24] is never needed.
    always_comb begin
        shifted = lo;
        case (off)
            2'd0: shifted = lo;
            2'd1: shifted = {hi[7:0],  lo[31:8]};
            2'd2: shifted = {hi[15:0], lo[31:16]};
            2'd3: shifted = {hi[23:0], lo[31:24]};
            default: shifted = lo;
        endcase
    end

    always_comb begin
        rdata = shifted;
        case (size)
            SIZE_B:  rdata = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
            SIZE_H:  rdata = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: rdata = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store initiator with word-split handling for an async-read data memory
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                request fields, sampled at the handshake
//   resp_valid, resp_rdata   one-cycle registered response
//   dmem_en, dmem_wbe,
//   dmem_addr, dmem_din      memory write/address port
//   dmem_dout                memory read data (combinational from dmem_addr)
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [AWIDTH+1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DWIDTH-1:0] resp_rdata,
    output logic              dmem_en,
    output logic [3:0]        dmem_wbe,
    output logic [AWIDTH-1:0] dmem_addr,
    output logic [DWIDTH-1:0] dmem_din,
    input  logic [DWIDTH-1:0] dmem_dout
);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic [AWIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lo_q, lo_d;
    logic [23:0]       hi_q, hi_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    logic [31:0] rot_din;
    logic [7:0]  mask;
    logic [31:0] ld_data;
    logic [31:0] lo_in;
    logic [23:0] hi_in;
    logic        split;
    logic        handshake;

    assign req_ready  = (state_q == IDLE) && !rst;
    assign handshake  = req_valid && req_ready;
    assign split      = |mask[7:4];
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

    // Forward the word being read this cycle so the response can be
    // registered on the same edge that ends the last access cycle.
    assign lo_in = (state_q == ACC0) ? dmem_dout : lo_q;
    assign hi_in = (state_q == ACC1) ? dmem_dout[23:0] : hi_q;

    dmem_lsu_align u_align (
        .wdata (wdata_q),
        .off   (off_q),
        .size  (size_q),
        .uns   (uns_q),
        .lo    (lo_in),
        .hi    (hi_in),
        .din   (rot_din),
        .mask  (mask),
        .rdata (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= SIZE_B;
            uns_q        <= 1'b0;
            off_q        <= 2'd0;
            waddr_q      <= '0;
            wdata_q      <= 32'h0;
            lo_q         <= 32'h0;
            hi_q         <= 24'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = ACC0;
            ACC0:    state_d = split ? ACC1 : RESP;
            ACC1:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        if (handshake) begin
            we_d    = req_we;
            size_d  = req_size;
            uns_d   = req_unsigned;
            off_d   = req_addr[1:0];
            waddr_d = req_addr[AWIDTH+1:2];
            wdata_d = req_wdata;
        end
        if (state_q == ACC0) lo_d = dmem_dout;
        if (state_q == ACC1) hi_d = dmem_dout[23:0];
        resp_valid_d = (state_d == RESP);
        resp_rdata_d = (state_d == RESP && !we_q) ? ld_data : 32'h0;
    end

    always_comb begin
        dmem_en   = 1'b0;
        dmem_wbe  = 4'h0;
        dmem_addr = '0;
        dmem_din  = '0;
        case (state_q)
            ACC0: begin
                dmem_en   = we_q && !rst;
                dmem_wbe  = we_q ? mask[3:0] : 4'h0;
                dmem_addr = waddr_q;
                dmem_din  = rot_din;
            end
            ACC1: begin
                dmem_en   = we_q && !rst;
                dmem_wbe  = we_q ? mask[7:4] : 4'h0;
                dmem_addr = waddr_q + AWIDTH'(1);
                dmem_din  = rot_din;
            end
            default: ;
        endcase
    end

endmodule
